// File: rtl/ecc_pkg.sv
// ecc_pkg: shared Hamming SEC layout constants and position mapping for encoder and decoder
package ecc_pkg;
  localparam int ECC_DATA_W = 32;
  localparam int ECC_CODE_W = 6;
  localparam int ECC_POS_MAX = 38;
  typedef enum logic {INJ_IDLE, INJ_ARMED} inj_state_e;
  typedef logic [ECC_DATA_W-1:0] pmask_t [ECC_CODE_W];
  // Data index stored at a codeword position, or -1 for check-bit/out-of-range positions.
  function automatic int pos_to_idx(input int pos);
    int lg;
    lg = 0;
    if (pos < 3 || pos > ECC_POS_MAX || (pos & (pos - 1)) == 0) return -1;
    while ((2 << lg) <= pos) lg++;
    return pos - lg - 2;
  endfunction
  function automatic int idx_to_pos(input int idx);
    for (int p = 3; p <= ECC_POS_MAX; p++)
      if (pos_to_idx(p) == idx) return p;
    return 0;
  endfunction
  function automatic logic [ECC_DATA_W-1:0] parity_mask(input int k);
    logic [ECC_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < ECC_DATA_W; i++) m[i] = ((idx_to_pos(i) >> k) & 1) != 0;
    return m;
  endfunction
  localparam pmask_t PARITY_MASK = '{parity_mask(0), parity_mask(1), parity_mask(2),
                                     parity_mask(3), parity_mask(4), parity_mask(5)};
endpackage

// File: rtl/hamming_parity32.sv
// hamming_parity32: check-bit contribution of a W-bit data slice starting at data index BASE
module hamming_parity32 import ecc_pkg::*; #(
  parameter int W = 16,
  parameter int BASE = 0
) (
  input  logic [W-1:0]          data,
  output logic [ECC_CODE_W-1:0] code
);
  for (genvar k = 0; k < ECC_CODE_W; k++) begin : g_par
    assign code[k] = ^(data & PARITY_MASK[k][BASE +: W]);
  end
endmodule

// File: rtl/ecc_encoder.sv
// ecc_encoder: two-stage Hamming SEC encoder with valid/ready handshake and one-shot error injection
module ecc_encoder import ecc_pkg::*; #(
  parameter int DATA_W = ECC_DATA_W,
  parameter int CODE_W = ECC_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              inj_req,
  input  logic [5:0]        inj_pos,
  output logic [DATA_W-1:0] out_data,
  output logic [CODE_W-1:0] out_code,
  output logic              out_inj,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              inj_pend
);
  logic s1_vld_q, s1_vld_d, s1_inj_q, s1_inj_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [CODE_W-1:0] s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d, par_lo, par_hi;
  logic [5:0] s1_pos_q, s1_pos_d, inj_pos_q, inj_pos_d;
  logic out_vld_q, out_vld_d, out_inj_q, out_inj_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, dflip;
  logic [CODE_W-1:0] out_code_q, out_code_d, cflip;
  inj_state_e inj_st_q, inj_st_d;
  logic s2_adv, s1_adv, acc, armed, ld2;
  hamming_parity32 #(.W(16), .BASE(0))  u_par_lo (.data(in_data[15:0]),  .code(par_lo));
  hamming_parity32 #(.W(16), .BASE(16)) u_par_hi (.data(in_data[31:16]), .code(par_hi));
  for (genvar k = 0; k < CODE_W; k++) begin : g_cflip
    assign cflip[k] = s1_inj_q && (s1_pos_q == 6'(1 << k));
  end
  for (genvar i = 0; i < DATA_W; i++) begin : g_dflip
    assign dflip[i] = s1_inj_q && (s1_pos_q == 6'(idx_to_pos(i)));
  end
  always_comb begin
    s2_adv = !out_vld_q || out_rdy;
    s1_adv = !s1_vld_q || s2_adv;
    acc = in_vld && s1_adv;
    armed = inj_st_q == INJ_ARMED;
    ld2 = s2_adv && s1_vld_q;
    s1_vld_d = s1_adv ? acc : s1_vld_q;
    s1_data_d = acc ? in_data : s1_data_q;
    s1_lo_d = acc ? par_lo : s1_lo_q;
    s1_hi_d = acc ? par_hi : s1_hi_q;
    s1_inj_d = acc ? armed : s1_inj_q;
    s1_pos_d = acc ? inj_pos_q : s1_pos_q;
    // A request seen while armed is dropped; the first latched position wins.
    inj_st_d = armed ? (acc ? INJ_IDLE : INJ_ARMED) : (inj_req ? INJ_ARMED : INJ_IDLE);
    inj_pos_d = (!armed && inj_req) ? inj_pos : inj_pos_q;
    out_vld_d = s2_adv ? s1_vld_q : out_vld_q;
    out_data_d = ld2 ? (s1_data_q ^ dflip) : out_data_q;
    out_code_d = ld2 ? (s1_lo_q ^ s1_hi_q ^ cflip) : out_code_q;
    out_inj_d = ld2 ? s1_inj_q : out_inj_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_inj_q <= 1'b0;
      s1_data_q <= '0;
      s1_lo_q <= '0;
      s1_hi_q <= '0;
      s1_pos_q <= '0;
      inj_st_q <= INJ_IDLE;
      inj_pos_q <= '0;
      out_vld_q <= 1'b0;
      out_data_q <= '0;
      out_code_q <= '0;
      out_inj_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_inj_q <= s1_inj_d;
      s1_data_q <= s1_data_d;
      s1_lo_q <= s1_lo_d;
      s1_hi_q <= s1_hi_d;
      s1_pos_q <= s1_pos_d;
      inj_st_q <= inj_st_d;
      inj_pos_q <= inj_pos_d;
      out_vld_q <= out_vld_d;
      out_data_q <= out_data_d;
      out_code_q <= out_code_d;
      out_inj_q <= out_inj_d;
    end
  end
  assign in_rdy = s1_adv;
  assign out_vld = out_vld_q;
  assign out_data = out_data_q;
  assign out_code = out_code_q;
  assign out_inj = out_inj_q;
  assign inj_pend = inj_st_q == INJ_ARMED;
endmodule

// File: tb/tb_ecc_encoder.sv
// tb_ecc_encoder: table vectors, corner sequences and randomized traffic against a codeword-level model
module tb_ecc_encoder;
  logic clk = 0, reset = 1, in_vld = 0, inj_req = 0, out_rdy = 1;
  logic [31:0] in_data = 0;
  logic [5:0] inj_pos = 0;
  logic in_rdy, out_inj, out_vld, inj_pend;
  logic [31:0] out_data;
  logic [5:0] out_code;
  int n_pass = 0, n_tot = 0;
  ecc_encoder dut (.clk(clk), .reset(reset), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .inj_req(inj_req), .inj_pos(inj_pos), .out_data(out_data), .out_code(out_code),
    .out_inj(out_inj), .out_vld(out_vld), .out_rdy(out_rdy), .inj_pend(inj_pend));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  function automatic logic [38:0] build(input logic [31:0] d, input logic [5:0] c);
    logic [38:0] cw;
    int j;
    cw = '0;
    j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) == 0) cw[p] = c[$clog2(p)];
      else begin cw[p] = d[j]; j++; end
    return cw;
  endfunction
  function automatic logic [31:0] data_of(input logic [38:0] cw);
    logic [31:0] d;
    int j;
    j = 0;
    d = '0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin d[j] = cw[p]; j++; end
    return d;
  endfunction
  function automatic logic [5:0] code_of(input logic [38:0] cw);
    logic [5:0] c;
    for (int k = 0; k < 6; k++) c[k] = cw[1 << k];
    return c;
  endfunction
  function automatic logic [5:0] syndrome(input logic [38:0] cw);
    logic [5:0] s;
    s = 0;
    for (int p = 1; p <= 38; p++) if (cw[p]) s ^= 6'(p);
    return s;
  endfunction
  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] cw;
    cw = build(d, 6'd0);
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (p != (1 << k) && ((p >> k) & 1) == 1) cw[1 << k] ^= cw[p];
    return cw;
  endfunction
  function automatic logic [31:0] correct(input logic [31:0] d, input logic [5:0] c);
    logic [38:0] cw;
    logic [5:0] s;
    cw = build(d, c);
    s = syndrome(cw);
    if (s >= 1 && s <= 38) cw[s] ^= 1'b1;
    return data_of(cw);
  endfunction
  typedef struct { logic [31:0] d; logic [5:0] c; logic inj; int pos; logic [31:0] orig; } exp_t;
  exp_t q[$];
  exp_t e;
  logic m_armed = 0;
  int m_pos = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_armed = 0;
      q.delete();
    end else if (in_vld && in_rdy) begin
      logic [38:0] cw;
      cw = encode(in_data);
      if (m_armed && m_pos >= 1 && m_pos <= 38) cw[m_pos] ^= 1'b1;
      q.push_back('{data_of(cw), code_of(cw), m_armed, m_armed ? m_pos : 0, in_data});
      if (m_armed) m_armed = 0;
      else if (inj_req) begin m_armed = 1; m_pos = int'(inj_pos); end
    end else if (!m_armed && inj_req) begin
      m_armed = 1;
      m_pos = int'(inj_pos);
    end
  end
  logic stall_prev = 0;
  logic [40:0] prev_out;
  int run = 0, maxrun = 0;
  logic [5:0] s_got;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      stall_prev = 0;
      run = 0;
    end else begin
      if (stall_prev) chk("stall_hold", 64'({out_vld, out_inj, out_code, out_data}), 64'(prev_out));
      if (out_vld && out_rdy) begin
        if (q.size() == 0) chk("unexpected_out", 64'(q.size()), 1);
        else begin
          e = q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_code", 64'(out_code), 64'(e.c));
          chk("out_inj", 64'(out_inj), 64'(e.inj));
          s_got = syndrome(build(out_data, out_code));
          chk("dec_syndrome", 64'(s_got), (e.inj && e.pos >= 1 && e.pos <= 38) ? 64'(e.pos) : 0);
          chk("dec_corrected", 64'(correct(out_data, out_code)), 64'(e.orig));
        end
      end
      stall_prev = out_vld && !out_rdy;
      prev_out = {out_vld, out_inj, out_code, out_data};
      run = out_vld ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
  end
  task automatic send(input logic [31:0] d, input logic req = 1'b0, input logic [5:0] pos = 6'd0);
    int t;
    t = 0;
    @(negedge clk);
    in_vld = 1; in_data = d; inj_req = req; inj_pos = pos;
    #1;
    while (!in_rdy && t < 50) begin @(negedge clk); #1; t++; end
    if (!in_rdy) begin
      chk("send_timeout", 0, 1);
      in_vld = 0; inj_req = 0;
      return;
    end
    @(posedge clk);
    #1 inj_req = 0;
  endtask
  task automatic arm(input logic [5:0] pos);
    @(negedge clk); inj_req = 1; inj_pos = pos;
    @(negedge clk); inj_req = 0;
  endtask
  task automatic wait_out(output logic [31:0] d, output logic inj);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_vld && t < 20);
    if (!out_vld) chk("wait_out_timeout", 0, 1);
    d = out_data; inj = out_inj;
  endtask
  typedef struct { logic [31:0] d; logic inj; logic [5:0] pos; logic [31:0] xd; logic [5:0] xc; logic xi; } vec_t;
  vec_t tbl[10];
  logic done = 0;
  logic [31:0] gd, w3;
  logic gi;
  initial begin
    tbl[0] = '{32'h0, 0, 0, 32'h0, 6'h00, 0};
    tbl[1] = '{32'h1, 0, 0, 32'h1, 6'h03, 0};
    tbl[2] = '{32'h2, 0, 0, 32'h2, 6'h05, 0};
    tbl[3] = '{32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 6'h18, 0};
    tbl[4] = '{32'h0, 1, 3, 32'h1, 6'h00, 1};
    tbl[5] = '{32'h0, 1, 8, 32'h0, 6'h08, 1};
    tbl[6] = '{32'h0, 1, 38, 32'h80000000, 6'h00, 1};
    tbl[7] = '{32'h0, 1, 0, 32'h0, 6'h00, 1};
    tbl[8] = '{32'h0, 1, 39, 32'h0, 6'h00, 1};
    tbl[9] = '{32'h80000000, 1, 1, 32'h80000000, 6'h27, 1};
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 1);
    chk("rst_out_vld", 64'(out_vld), 0);
    chk("rst_out_inj", 64'(out_inj), 0);
    chk("rst_inj_pend", 64'(inj_pend), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_code", 64'(out_code), 0);
    foreach (tbl[i]) begin
      if (tbl[i].inj) arm(tbl[i].pos);
      send(tbl[i].d);
      in_vld = 0;
      @(negedge clk);
      chk($sformatf("v%0d_lat1", i), 64'(out_vld), 0);
      @(negedge clk);
      chk($sformatf("v%0d_vld", i), 64'(out_vld), 1);
      chk($sformatf("v%0d_data", i), 64'(out_data), 64'(tbl[i].xd));
      chk($sformatf("v%0d_code", i), 64'(out_code), 64'(tbl[i].xc));
      chk($sformatf("v%0d_inj", i), 64'(out_inj), 64'(tbl[i].xi));
    end
    repeat (3) @(negedge clk);
    maxrun = 0;
    for (int i = 0; i < 8; i++) send($urandom);
    in_vld = 0;
    repeat (4) @(negedge clk);
    chk("b2b_run", 64'(maxrun), 8);
    out_rdy = 0;
    send($urandom);
    send($urandom);
    w3 = $urandom;
    @(negedge clk);
    in_vld = 1; in_data = w3;
    #1 chk("full_in_rdy", 64'(in_rdy), 0);
    repeat (4) begin @(negedge clk); #1 chk("stall_in_rdy", 64'(in_rdy), 0); end
    @(negedge clk);
    out_rdy = 1;
    #1 chk("rdy_follow", 64'(in_rdy), 1);
    @(posedge clk);
    #1 in_vld = 0;
    repeat (5) @(negedge clk);
    chk("stall_drain", 64'(q.size()), 0);
    send(32'hA5A5_0F0F, 1, 5);
    chk("coin_pend", 64'(inj_pend), 1);
    send(32'h1234_5678, 1, 9);
    in_vld = 0;
    wait_out(gd, gi);
    chk("coin_first_inj", 64'(gi), 0);
    chk("coin_first_data", 64'(gd), 64'(32'hA5A5_0F0F));
    wait_out(gd, gi);
    chk("coin_second_inj", 64'(gi), 1);
    chk("coin_second_data", 64'(gd), 64'(32'h1234_567A));
    chk("coin_pend_clear", 64'(inj_pend), 0);
    repeat (3) @(negedge clk);
    out_rdy = 0;
    send($urandom);
    send($urandom);
    in_vld = 0;
    arm(7);
    #1;
    chk("pre_rst_pend", 64'(inj_pend), 1);
    chk("pre_rst_vld", 64'(out_vld), 1);
    chk("pre_rst_rdy", 64'(in_rdy), 0);
    @(negedge clk) reset = 1;
    @(negedge clk);
    chk("mid_rst_vld", 64'(out_vld), 0);
    chk("mid_rst_pend", 64'(inj_pend), 0);
    chk("mid_rst_rdy", 64'(in_rdy), 1);
    reset = 0;
    out_rdy = 1;
    repeat (4) @(negedge clk);
    chk("post_rst_vld", 64'(out_vld), 0);
    fork
      begin
        for (int i = 0; i < 40; i++)
          send($urandom, $urandom_range(0, 5) == 0, 6'($urandom_range(0, 40)));
        in_vld = 0;
        done = 1;
      end
      begin
        while (!done) begin @(negedge clk); out_rdy = $urandom_range(0, 3) != 0; end
        out_rdy = 1;
      end
    join
    repeat (8) @(negedge clk);
    chk("rand_drain", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
